// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_pkg;

  // Accumulator-side state of the packer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_DONE  = 2'd2
  } packer_state_t;

  // Widest lane mask the helper can produce; callers truncate to their RATIO.
  localparam int unsigned KEEP_MAX = 32;

  // Thermometer mask: the lowest cnt bits set.
  function automatic logic [KEEP_MAX-1:0] keep_therm(input int unsigned cnt);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops words from a first-word-fall-through FIFO and packs RATIO of them into
// one wide valid/ready beat. Partial beats leave on idle timeout or flush.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [WIDTH-1:0]       fifo_data_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_en_o,
  input  logic                   flush_i,
  output logic [WIDTH*RATIO-1:0] m_data_o,
  output logic [RATIO-1:0]       m_keep_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i
);

  localparam int unsigned CNT_W = $clog2(RATIO + 1);
  localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);

  packer_state_t                     state_q, state_d;
  logic          [CNT_W-1:0]         acc_cnt_q, acc_cnt_d, acc_base;
  logic          [RATIO-1:0][WIDTH-1:0] lanes_q, lanes_d, lane_mask;
  logic          [WIDTH*RATIO-1:0]   m_data_q, m_data_d;
  logic          [RATIO-1:0]         m_keep_q, m_keep_d, keep_vec;
  logic                              m_valid_q, m_valid_d;

  logic out_free, transfer, flush_hit, pop, timeout_hit;

  // The output register can accept a beat when empty or being drained now.
  assign out_free  = ~m_valid_q | m_ready_i;
  assign transfer  = (state_q == ST_DONE) & out_free;
  assign flush_hit = (state_q == ST_FILL) & flush_i;
  // Pop gating uses out_free combinationally, so no skid stage is needed.
  assign pop = rst_n_i & ~fifo_empty_i & ((state_q != ST_DONE) | transfer) & ~flush_hit;

  assign fifo_rd_en_o = pop;
  assign m_data_o     = m_data_q;
  assign m_keep_o     = m_keep_q;
  assign m_valid_o    = m_valid_q;

  // Lanes at or above acc_cnt are masked off so partial beats carry zeros.
  assign keep_vec = RATIO'(keep_therm(32'(acc_cnt_q)));
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_mask
    assign lane_mask[gi] = {WIDTH{keep_vec[gi]}};
  end

  // Idle timer: counts non-popping cycles in ST_FILL and saturates.
  if (TIMEOUT > 0) begin : g_timeout
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    // Count idle fill cycles; anything else clears the timer.
    always_comb begin
      idle_cnt_d = '0;
      if ((state_q == ST_FILL) && !pop) begin
        idle_cnt_d = (idle_cnt_q == IDLE_W'(TIMEOUT)) ? idle_cnt_q : idle_cnt_q + 1'b1;
      end
    end

    // Idle timer register.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) idle_cnt_q <= '0;
      else          idle_cnt_q <= idle_cnt_d;
    end

    assign timeout_hit = (state_q == ST_FILL) & ~pop & (idle_cnt_q == IDLE_W'(TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  // Next-state: accumulator fill, acc->out transfer and output handshake.
  always_comb begin
    acc_base  = transfer ? '0 : acc_cnt_q;
    acc_cnt_d = acc_base;
    lanes_d   = lanes_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_valid_d = m_valid_q & ~m_ready_i;
    state_d   = state_q;

    if (transfer) begin
      m_data_d  = lanes_q & lane_mask;
      m_keep_d  = keep_vec;
      m_valid_d = 1'b1;
    end

    if (pop) begin
      acc_cnt_d = acc_base + 1'b1;
      for (int unsigned l = 0; l < RATIO; l++) begin
        if (acc_base == CNT_W'(l)) lanes_d[l] = fifo_data_i;
      end
    end

    if ((state_q == ST_DONE) && !transfer) state_d = ST_DONE;
    else if (flush_hit || timeout_hit)     state_d = ST_DONE;
    else if (acc_cnt_d == RATIO_C)         state_d = ST_DONE;
    else if (acc_cnt_d == '0)              state_d = ST_EMPTY;
    else                                   state_d = ST_FILL;
  end

  // State, accumulator and output registers; reset discards everything.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_EMPTY;
      acc_cnt_q <= '0;
      lanes_q   <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      lanes_q   <= lanes_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (WIDTH=8, RATIO=4, TIMEOUT=16).
module tb_fifo_word_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_i      = 1'b0;
  logic [7:0]  fifo_data_i  = 8'h00;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rd_en_o;
  logic        flush_i      = 1'b0;
  logic [31:0] m_data_o;
  logic [3:0]  m_keep_o;
  logic        m_valid_o;
  logic        m_ready_i    = 1'b1;

  fifo_word_packer #(.WIDTH(8), .RATIO(4), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .fifo_data_i(fifo_data_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o), .flush_i(flush_i),
    .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  int checks = 0, failures = 0, cyc = 0;
  logic [7:0]  fq[$];
  logic [35:0] beats[$];
  int          beat_cyc[$];
  int pop_cnt = 0, first_pop = -1, last_pop = -1, rd_viol = 0, hold_viol = 0;
  logic rst_set = 1'b0, ready_set = 1'b1, stall = 1'b0, flush_set = 1'b0;
  logic prev_stall = 1'b0;
  logic [35:0] prev_out = '0;

  typedef struct {
    int          nwords;
    logic [7:0]  base;
    bit          use_flush;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    int          exp_lat;   // cycles from last pop to the handshake
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample just before the next posedge.
  task automatic step();
    @(negedge clk);
    rst_n_i      = rst_set;
    fifo_empty_i = (fq.size() == 0) || stall;
    fifo_data_i  = (fq.size() > 0) ? fq[0] : 8'h00;
    m_ready_i    = ready_set;
    flush_i      = flush_set;
    #4;
    if (fifo_rd_en_o && fifo_empty_i) rd_viol++;
    if (prev_stall && (!m_valid_o || {m_keep_o, m_data_o} != prev_out)) hold_viol++;
    prev_stall = m_valid_o && !m_ready_i && rst_n_i;
    prev_out   = {m_keep_o, m_data_o};
    if (fifo_rd_en_o && !fifo_empty_i) begin
      void'(fq.pop_front());
      pop_cnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (m_valid_o && m_ready_i && rst_n_i) begin
      beats.push_back({m_keep_o, m_data_o});
      beat_cyc.push_back(cyc);
      $display("beat %0d cyc=%0d data=%08h keep=%h", beats.size() - 1, cyc, m_data_o, m_keep_o);
    end
    cyc++;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      step();
      k++;
    end
    if (beats.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0d beats expected %0d (timeout)", name, beats.size(), n);
    end
  endtask

  task automatic drain_fifo();
    int k = 0;
    while (fq.size() > 0 && k < 100) begin
      step();
      k++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n0, pc0;
    logic [7:0] sent[$];
    logic [7:0] got[$];
    int bad_keep, mism;

    vecs[0] = '{4, 8'h40, 1'b0, 32'h43424140, 4'hF, 2};
    vecs[1] = '{3, 8'h10, 1'b1, 32'h00121110, 4'h7, 3};
    vecs[2] = '{1, 8'h5A, 1'b1, 32'h0000005A, 4'h1, 3};
    vecs[3] = '{2, 8'hA1, 1'b0, 32'h0000A2A1, 4'h3, 18};
    vecs[4] = '{3, 8'hC0, 1'b1, 32'h00C2C1C0, 4'h7, 3};
    vecs[5] = '{4, 8'hF0, 1'b0, 32'hF3F2F1F0, 4'hF, 2};

    // Reset: outputs cleared and no pop even with a word available.
    rst_set = 1'b0;
    fq.push_back(8'hEE);
    idle(3);
    check("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
    check("rst_valid", 64'(m_valid_o), 64'd0);
    check("rst_keep",  64'(m_keep_o), 64'd0);
    check("rst_data",  64'(m_data_o), 64'd0);
    fq.delete();
    rst_set = 1'b1;
    idle(2);

    // Back-to-back stream: 1 pop/cycle, beat every RATIO cycles.
    n0 = beats.size();
    first_pop = -1;
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
    wait_beats(n0 + 2, 30, "thru_wait");
    if (beats.size() >= n0 + 2) begin
      check("thru_pops_contig", 64'(last_pop - first_pop), 64'd7);
      check("thru_beat0", 64'(beats[n0]), {28'd0, 4'hF, 32'h04030201});
      check("thru_beat1", 64'(beats[n0+1]), {28'd0, 4'hF, 32'h08070605});
      check("thru_first_lat", 64'(beat_cyc[n0] - first_pop), 64'd5);
      check("thru_spacing", 64'(beat_cyc[n0+1] - beat_cyc[n0]), 64'd4);
    end
    idle(3);

    // Table: full, flushed and timed-out partial beats.
    foreach (vecs[v]) begin
      n0 = beats.size();
      for (int i = 0; i < vecs[v].nwords; i++) fq.push_back(vecs[v].base + 8'(i));
      drain_fifo();
      if (vecs[v].use_flush) begin
        flush_set = 1'b1;
        step();
        flush_set = 1'b0;
      end
      wait_beats(n0 + 1, 40, $sformatf("vec%0d_wait", v));
      if (beats.size() >= n0 + 1) begin
        check($sformatf("vec%0d_data", v), 64'(beats[n0][31:0]), 64'(vecs[v].exp_data));
        check($sformatf("vec%0d_keep", v), 64'(beats[n0][35:32]), 64'(vecs[v].exp_keep));
        check($sformatf("vec%0d_lat", v), 64'(beat_cyc[n0] - last_pop), 64'(vecs[v].exp_lat));
      end
      idle(25);
      check($sformatf("vec%0d_no_extra", v), 64'(beats.size()), 64'(n0 + 1));
    end

    // Flush with an empty accumulator emits nothing.
    n0 = beats.size();
    flush_set = 1'b1;
    step();
    flush_set = 1'b0;
    idle(25);
    check("flush_empty_none", 64'(beats.size()), 64'(n0));

    // Backpressure: one beat held, accumulator fills, then pops stop.
    n0 = beats.size();
    pc0 = pop_cnt;
    ready_set = 1'b0;
    for (int i = 0; i < 12; i++) fq.push_back(8'h20 + 8'(i));
    idle(15);
    check("bp_pops", 64'(pop_cnt - pc0), 64'd8);
    check("bp_valid", 64'(m_valid_o), 64'd1);
    check("bp_data", 64'(m_data_o), 64'h23222120);
    check("bp_rd_en", 64'(fifo_rd_en_o), 64'd0);
    ready_set = 1'b1;
    wait_beats(n0 + 3, 40, "bp_wait");
    if (beats.size() >= n0 + 3) begin
      check("bp_beat0", 64'(beats[n0]),   {28'd0, 4'hF, 32'h23222120});
      check("bp_beat1", 64'(beats[n0+1]), {28'd0, 4'hF, 32'h27262524});
      check("bp_beat2", 64'(beats[n0+2]), {28'd0, 4'hF, 32'h2B2A2928});
    end
    idle(3);

    // Reset with a pending beat and two accumulated words.
    ready_set = 1'b0;
    for (int i = 0; i < 6; i++) fq.push_back(8'h50 + 8'(i));
    idle(10);
    check("mrst_pre_valid", 64'(m_valid_o), 64'd1);
    rst_set = 1'b0;
    fq.delete();
    step();
    rst_set = 1'b1;
    step();
    check("mrst_valid", 64'(m_valid_o), 64'd0);
    check("mrst_data",  64'({m_keep_o, m_data_o}), 64'd0);
    ready_set = 1'b1;
    n0 = beats.size();
    for (int i = 1; i <= 4; i++) fq.push_back(8'h30 + 8'(i));
    wait_beats(n0 + 1, 30, "mrst_wait");
    if (beats.size() >= n0 + 1)
      check("mrst_fresh_beat", 64'(beats[n0]), {28'd0, 4'hF, 32'h34333231});
    idle(25);
    check("mrst_no_extra", 64'(beats.size()), 64'(n0 + 1));

    // Random ready/empty: order preserved, nothing lost or duplicated.
    n0 = beats.size();
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      fq.push_back(w);
      sent.push_back(w);
    end
    begin
      int k = 0;
      while (fq.size() > 0 && k < 20000) begin
        stall     = ($urandom_range(0, 3) == 0);
        ready_set = ($urandom_range(0, 3) != 0);
        step();
        k++;
      end
    end
    stall = 1'b0;
    ready_set = 1'b1;
    idle(40);
    bad_keep = 0;
    for (int b = n0; b < beats.size(); b++) begin
      logic [3:0] kp;
      kp = beats[b][35:32];
      if (!(kp == 4'h1 || kp == 4'h3 || kp == 4'h7 || kp == 4'hF)) bad_keep++;
      for (int l = 0; l < 4; l++)
        if (kp[l]) got.push_back(beats[b][8*l +: 8]);
    end
    mism = 0;
    for (int i = 0; i < 1000; i++)
      if (i >= got.size() || got[i] !== sent[i]) mism++;
    check("rand_count", 64'(got.size()), 64'd1000);
    check("rand_order", 64'(mism), 64'd0);
    check("rand_keep", 64'(bad_keep), 64'd0);

    check("never_pop_empty", 64'(rd_viol), 64'd0);
    check("output_hold", 64'(hold_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
